// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared 7-segment bit positions, digit glyphs and frame sizes
//                for the serial display link (transmit and receive sides).
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Glyphs are {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_6_ALT = 7'h7C;
    localparam logic [6:0] GLYPH_7_ALT = 7'h27;
    localparam logic [6:0] GLYPH_9_ALT = 7'h67;

    localparam int DEFAULT_NUM_DIGITS     = 6;
    localparam int DEFAULT_BITS_PER_DIGIT = 8;

endpackage
`default_nettype wire

// File: rtl/serial_display_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_display_receiver_if
//  Description : 3-wire serial display link (data, latch, shift clock).
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_display_receiver_if;

    logic serial_data;
    logic serial_latch;
    logic serial_clk;

    modport master (output serial_data, serial_latch, serial_clk);
    modport slave  (input  serial_data, serial_latch, serial_clk);

endinterface
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Combinational 7-segment glyph to BCD decode with invalid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import display_pkg::*;
(
    input  wire logic [6:0] i_segments,
    output logic      [3:0] o_bcd,
    output logic            o_invalid
);

    always_comb begin
        o_bcd     = 4'd0;
        o_invalid = 1'b0;
        case (i_segments)
            GLYPH_0:     o_bcd = 4'd0;
            GLYPH_1:     o_bcd = 4'd1;
            GLYPH_2:     o_bcd = 4'd2;
            GLYPH_3:     o_bcd = 4'd3;
            GLYPH_4:     o_bcd = 4'd4;
            GLYPH_5:     o_bcd = 4'd5;
            GLYPH_6:     o_bcd = 4'd6;
            GLYPH_7:     o_bcd = 4'd7;
            GLYPH_8:     o_bcd = 4'd8;
            GLYPH_9:     o_bcd = 4'd9;
            GLYPH_6_ALT: o_bcd = 4'd6;
            GLYPH_7_ALT: o_bcd = 4'd7;
            GLYPH_9_ALT: o_bcd = 4'd9;
            default:     o_invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/serial_display_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_display_receiver
//  Description : Oversampling receiver for the serial display link; shifts in
//                a frame, transfers it on latch and decodes each digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_display_receiver
    import display_pkg::*;
#(
    parameter int NUM_DIGITS     = DEFAULT_NUM_DIGITS,
    parameter int BITS_PER_DIGIT = DEFAULT_BITS_PER_DIGIT
) (
    input  wire logic                                 i_clk,
    input  wire logic                                 i_reset_n,
    input  wire logic                                 i_en,
    serial_display_receiver_if.slave                  link,
    output logic [NUM_DIGITS*BITS_PER_DIGIT-1:0]      o_segments,
    output logic [4*NUM_DIGITS-1:0]                   o_digits,
    output logic [NUM_DIGITS-1:0]                     o_digit_invalid,
    output logic [NUM_DIGITS-1:0]                     o_dp,
    output logic                                      o_frame_valid,
    output logic                                      o_frame_error
);

    localparam int FRAME_BITS = NUM_DIGITS * BITS_PER_DIGIT;
    localparam int c_COUNT_W  = $clog2(FRAME_BITS + 2);
    localparam logic [c_COUNT_W-1:0] c_COUNT_FULL = c_COUNT_W'(FRAME_BITS);
    localparam logic [c_COUNT_W-1:0] c_COUNT_MAX  = c_COUNT_W'(FRAME_BITS + 1);

    logic [1:0]            r_data_sync;
    logic [2:0]            r_sclk_sync;
    logic [2:0]            r_latch_sync;
    logic [FRAME_BITS-1:0] r_shift;
    logic [c_COUNT_W-1:0]  r_count;
    logic [FRAME_BITS-1:0] r_segments;
    logic                  r_frame_valid;
    logic                  r_frame_error;

    logic                  w_shift_fire;
    logic                  w_latch_fire;
    logic [FRAME_BITS-1:0] w_shift_next;
    logic [c_COUNT_W-1:0]  w_count_next;

    assign w_shift_fire = i_en & r_sclk_sync[1]  & ~r_sclk_sync[2];
    assign w_latch_fire = i_en & r_latch_sync[1] & ~r_latch_sync[2];

    // A same-cycle latch sees the post-shift frame and count
    always_comb begin
        w_shift_next = r_shift;
        w_count_next = r_count;
        if (w_shift_fire) begin
            w_shift_next = {r_shift[FRAME_BITS-2:0], r_data_sync[1]};
            if (r_count != c_COUNT_MAX) begin
                w_count_next = r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data_sync   <= '0;
            r_sclk_sync   <= '0;
            r_latch_sync  <= '0;
            r_shift       <= '0;
            r_count       <= '0;
            r_segments    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_data_sync   <= {r_data_sync[0], link.serial_data};
            r_sclk_sync   <= {r_sclk_sync[1:0], link.serial_clk};
            r_latch_sync  <= {r_latch_sync[1:0], link.serial_latch};
            r_shift       <= w_shift_next;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            if (w_latch_fire) begin
                r_count <= '0;
                if (w_count_next == c_COUNT_FULL) begin
                    r_segments    <= w_shift_next;
                    r_frame_valid <= 1'b1;
                end else begin
                    r_frame_error <= 1'b1;
                end
            end else begin
                r_count <= w_count_next;
            end
        end
    end

    assign o_segments    = r_segments;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_error = r_frame_error;

    // Digit 0 occupies the most significant slice of every output vector
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        localparam int c_BYTE_LSB = BITS_PER_DIGIT * (NUM_DIGITS - 1 - gi);
        localparam int c_NIB_LSB  = 4 * (NUM_DIGITS - 1 - gi);

        seg7_decoder u_seg7_decoder (
            .i_segments (r_segments[c_BYTE_LSB + SEG_A +: 7]),
            .o_bcd      (o_digits[c_NIB_LSB +: 4]),
            .o_invalid  (o_digit_invalid[NUM_DIGITS - 1 - gi])
        );

        assign o_dp[NUM_DIGITS - 1 - gi] = r_segments[c_BYTE_LSB + SEG_DP];
    end

endmodule
`default_nettype wire
